// File: rtl/results_writer.sv
// Streams a solver's T/X result beats into RAM, then writes the T count and Num_X words.
// Optional macro RESULTS_WRITER_CHECKSUM_EN adds an XOR checksum word written to address 0.
module results_writer #(
  parameter int unsigned ADDRESS_WIDTH         = 13,
  parameter int unsigned DATA_WIDTH            = 64,
  parameter int unsigned NUMBER_OF_T_ADDRESS   = 1,
  parameter int unsigned NUMBER_OF_X_ADDRESS   = 2,
  parameter int unsigned STARTING_OF_T_ADDRESS = 3,
  parameter int unsigned STARTING_OF_X_ADDRESS = 10,
  parameter int unsigned MAX_T                 = 7
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  input  logic [DATA_WIDTH-1:0]    Num_X,
  input  logic                     Result_Valid,
  input  logic [DATA_WIDTH-1:0]    Result_Data,
  input  logic                     Result_Last,
  output logic                     Result_Ready,
  output logic                     RAM_Write_Enable,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address,
  output logic [DATA_WIDTH-1:0]    RAM_Data_Out,
  output logic                     Done_Writing,
  output logic                     Overflow_Error
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WAIT_T   = 3'd1;
  localparam logic [2:0] WAIT_X   = 3'd2;
  localparam logic [2:0] WRITE_NT = 3'd3;
  localparam logic [2:0] WRITE_NX = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;
`ifdef RESULTS_WRITER_CHECKSUM_EN
  localparam logic [2:0] WRITE_CK = 3'd6;
`endif

  logic [2:0]               state_q, state_d;
  logic [DATA_WIDTH-1:0]    num_x_q, num_x_d;
  logic [DATA_WIDTH-1:0]    t_count_q, t_count_d;
  logic [DATA_WIDTH-1:0]    x_count_q, x_count_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     done_q, done_d;
  logic                     ovf_q, ovf_d;
  logic                     beat;
  logic [DATA_WIDTH-1:0]    t_addr, x_addr;
`ifdef RESULTS_WRITER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]    ck_q, ck_d;
`endif

  assign Result_Ready = (state_q == WAIT_T) || (state_q == WAIT_X);
  assign beat         = Result_Valid && Result_Ready;

  // Full-width address arithmetic; only the low ADDRESS_WIDTH bits reach the RAM.
  assign t_addr = DATA_WIDTH'(STARTING_OF_T_ADDRESS) + t_count_q;
  assign x_addr = DATA_WIDTH'(STARTING_OF_X_ADDRESS) + t_count_q * num_x_q + x_count_q;

  always_comb begin
    state_d   = state_q;
    num_x_d   = num_x_q;
    t_count_d = t_count_q;
    x_count_d = x_count_q;
    we_d      = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
`ifdef RESULTS_WRITER_CHECKSUM_EN
    ck_d      = ck_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        done_d = (state_q == DONE);
        if (Start) begin
          num_x_d   = Num_X;
          t_count_d = '0;
          x_count_d = '0;
          done_d    = 1'b0;
          ovf_d     = 1'b0;
`ifdef RESULTS_WRITER_CHECKSUM_EN
          ck_d      = '0;
`endif
          state_d   = WAIT_T;
        end
      end
      WAIT_T: begin
        if (beat) begin
          if (t_count_q == DATA_WIDTH'(MAX_T)) begin
            // Capacity exhausted: drop the beat and close the run as if it were last.
            ovf_d   = 1'b1;
            state_d = WRITE_NT;
          end else begin
            we_d    = 1'b1;
            addr_d  = t_addr[ADDRESS_WIDTH-1:0];
            wdata_d = Result_Data;
`ifdef RESULTS_WRITER_CHECKSUM_EN
            ck_d    = ck_q ^ Result_Data;
`endif
            if (Result_Last) begin
              t_count_d = t_count_q + 1'b1;
              state_d   = WRITE_NT;
            end else if (num_x_q == '0) begin
              t_count_d = t_count_q + 1'b1;
            end else begin
              state_d = WAIT_X;
            end
          end
        end
      end
      WAIT_X: begin
        if (beat) begin
          we_d    = 1'b1;
          addr_d  = x_addr[ADDRESS_WIDTH-1:0];
          wdata_d = Result_Data;
`ifdef RESULTS_WRITER_CHECKSUM_EN
          ck_d    = ck_q ^ Result_Data;
`endif
          if (Result_Last || (x_count_q == num_x_q - 1'b1)) begin
            // A partial group closed by Last still counts its T.
            x_count_d = '0;
            t_count_d = t_count_q + 1'b1;
            state_d   = Result_Last ? WRITE_NT : WAIT_T;
          end else begin
            x_count_d = x_count_q + 1'b1;
          end
        end
      end
      WRITE_NT: begin
        we_d    = 1'b1;
        addr_d  = ADDRESS_WIDTH'(NUMBER_OF_T_ADDRESS);
        wdata_d = t_count_q;
        state_d = WRITE_NX;
      end
      WRITE_NX: begin
        we_d    = 1'b1;
        addr_d  = ADDRESS_WIDTH'(NUMBER_OF_X_ADDRESS);
        wdata_d = num_x_q;
`ifdef RESULTS_WRITER_CHECKSUM_EN
        state_d = WRITE_CK;
`else
        state_d = DONE;
`endif
      end
`ifdef RESULTS_WRITER_CHECKSUM_EN
      WRITE_CK: begin
        we_d    = 1'b1;
        addr_d  = '0;
        wdata_d = ck_q;
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q   <= IDLE;
      num_x_q   <= '0;
      t_count_q <= '0;
      x_count_q <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
`ifdef RESULTS_WRITER_CHECKSUM_EN
      ck_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      num_x_q   <= num_x_d;
      t_count_q <= t_count_d;
      x_count_q <= x_count_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
`ifdef RESULTS_WRITER_CHECKSUM_EN
      ck_q      <= ck_d;
`endif
    end
  end

  assign RAM_Write_Enable = we_q;
  assign RAM_Address      = addr_q;
  assign RAM_Data_Out     = wdata_q;
  assign Done_Writing     = done_q;
  assign Overflow_Error   = ovf_q;

endmodule

// File: tb/tb_results_writer.sv
// Randomized self-checking bench for results_writer against a beat-list reference model.
module tb_results_writer;

  localparam int MAX_T = 7;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        Start = 1'b0;
  logic [63:0] Num_X = '0;
  logic        Result_Valid = 1'b0;
  logic [63:0] Result_Data = '0;
  logic        Result_Last = 1'b0;
  logic        Result_Ready;
  logic        RAM_Write_Enable;
  logic [12:0] RAM_Address;
  logic [63:0] RAM_Data_Out;
  logic        Done_Writing;
  logic        Overflow_Error;

  results_writer dut (
    .CLK              (CLK),
    .RST              (RST),
    .Start            (Start),
    .Num_X            (Num_X),
    .Result_Valid     (Result_Valid),
    .Result_Data      (Result_Data),
    .Result_Last      (Result_Last),
    .Result_Ready     (Result_Ready),
    .RAM_Write_Enable (RAM_Write_Enable),
    .RAM_Address      (RAM_Address),
    .RAM_Data_Out     (RAM_Data_Out),
    .Done_Writing     (Done_Writing),
    .Overflow_Error   (Overflow_Error)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  logic [79:0] obs_q[$];
  logic [79:0] exp_q[$];
  logic [63:0] beat_data [64];
  int          exp_nacc;
  logic        exp_ovf;

  always @(negedge CLK) begin
    if (RAM_Write_Enable === 1'b1) obs_q.push_back({3'b0, RAM_Address, RAM_Data_Out});
  end

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [79:0] pack(input int a, input logic [63:0] d);
    logic [31:0] av;
    av = a;
    return {3'b0, av[12:0], d};
  endfunction

  // Expected write list from the layout rules: group = one T then nx X values.
  task automatic build_model(input int nx, input int nbeats, input int last_idx);
    int t, pos;
    logic [63:0] ck;
    t = 0; pos = 0; ck = '0;
    exp_q.delete();
    exp_ovf  = 1'b0;
    exp_nacc = 0;
    for (int i = 0; i < nbeats; i++) begin
      exp_nacc++;
      if (pos == 0 && t == MAX_T) begin
        exp_ovf = 1'b1;
        break;
      end
      if (pos == 0) exp_q.push_back(pack(3 + t, beat_data[i]));
      else          exp_q.push_back(pack(10 + t * nx + pos - 1, beat_data[i]));
      ck ^= beat_data[i];
      if (i == last_idx) begin
        t++;
        break;
      end
      pos++;
      if (pos == nx + 1) begin
        pos = 0;
        t++;
      end
    end
    exp_q.push_back(pack(1, 64'(t)));
    exp_q.push_back(pack(2, 64'(nx)));
`ifdef RESULTS_WRITER_CHECKSUM_EN
    exp_q.push_back(pack(0, ck));
`endif
  endtask

  task automatic pulse_start(input int nx);
    Start = 1'b1;
    Num_X = 64'(nx);
    @(posedge CLK); #1;
    Start = 1'b0;
  endtask

  task automatic drive_beats(input int n_acc, input int last_idx, input int glitch_idx);
    int  i, budget;
    bit  acc, glitched;
    i = 0; budget = 0; glitched = 0;
    while (i < n_acc && budget < 1000) begin
      Result_Valid = ($urandom_range(0, 3) != 0);
      Result_Data  = beat_data[i];
      Result_Last  = (i == last_idx);
      if (i == glitch_idx && !glitched) begin
        Start = 1'b1;
        Num_X = 64'd5;
        glitched = 1;
      end
      @(negedge CLK);
      acc = Result_Valid && Result_Ready;
      @(posedge CLK); #1;
      Start = 1'b0;
      if (acc) i++;
      budget++;
    end
    if (i < n_acc) check("drive_timeout", 80'(i), 80'(n_acc));
    Result_Valid = 1'b0;
    Result_Last  = 1'b0;
  endtask

  task automatic run_case(input string tag, input int nx, input int nbeats, input int last_idx,
                          input int glitch_idx);
    int cycles;
    build_model(nx, nbeats, last_idx);
    obs_q.delete();
    pulse_start(nx);
    check({tag, "_done_clr"}, 80'(Done_Writing), 80'(0));
    check({tag, "_ovf_clr"}, 80'(Overflow_Error), 80'(0));
    drive_beats(exp_nacc, last_idx, glitch_idx);
    cycles = 0;
    while (Done_Writing !== 1'b1 && cycles < 100) begin
      @(posedge CLK); #1;
      cycles++;
    end
    check({tag, "_done"}, 80'(Done_Writing), 80'(1));
    repeat (3) @(posedge CLK);
    #1;
    check({tag, "_nwrites"}, 80'(obs_q.size()), 80'(exp_q.size()));
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++)
      check($sformatf("%s_write%0d", tag, k), obs_q[k], exp_q[k]);
    check({tag, "_ovf"}, 80'(Overflow_Error), 80'(exp_ovf));
  endtask

  initial begin
    int nx, nb;
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", 80'(Result_Ready), 80'(0));
    check("rst_we", 80'(RAM_Write_Enable), 80'(0));
    check("rst_outs", {3'b0, RAM_Address, RAM_Data_Out}, 80'(0));
    check("rst_done", 80'(Done_Writing), 80'(0));
    check("rst_ovf", 80'(Overflow_Error), 80'(0));
    RST = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 6; i++) beat_data[i] = 64'(i + 5);
    run_case("nx2", 2, 6, 5, -1);

    for (int i = 0; i < 3; i++) beat_data[i] = 64'(i + 1);
    run_case("nx0", 0, 3, 2, -1);

    for (int i = 0; i < 16; i++) beat_data[i] = {$urandom, $urandom};
    run_case("ovf", 1, 16, -1, -1);

    for (int i = 0; i < 6; i++) beat_data[i] = {$urandom, $urandom};
    run_case("glitch", 2, 6, 5, 1);

    for (int r = 0; r < 6; r++) begin
      nx = $urandom_range(0, 3);
      nb = $urandom_range(1, 30);
      for (int i = 0; i < nb; i++) beat_data[i] = {$urandom, $urandom};
      run_case($sformatf("rnd%0d", r), nx, nb, nb - 1, -1);
    end

    // Mid-run reset while waiting for X beats.
    beat_data[0] = 64'h1234;
    pulse_start(2);
    drive_beats(1, -1, -1);
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    check("mrst_ready", 80'(Result_Ready), 80'(0));
    check("mrst_we", 80'(RAM_Write_Enable), 80'(0));
    check("mrst_outs", {3'b0, RAM_Address, RAM_Data_Out}, 80'(0));
    check("mrst_done", 80'(Done_Writing), 80'(0));
    check("mrst_ovf", 80'(Overflow_Error), 80'(0));
    obs_q.delete();
    Result_Valid = 1'b1;
    Result_Last  = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    Result_Valid = 1'b0;
    Result_Last  = 1'b0;
    check("mrst_nwrites", 80'(obs_q.size()), 80'(0));
    check("mrst_idle_ready", 80'(Result_Ready), 80'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/results_writer.md
RESULTS_WRITER -- requirements
Module: results_writer

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 13, the RAM address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, the RAM and result word width.
REQ-003 SHALL have parameters NUMBER_OF_T_ADDRESS=1, NUMBER_OF_X_ADDRESS=2, STARTING_OF_T_ADDRESS=3, STARTING_OF_X_ADDRESS=10 and MAX_T=7, which fix the result RAM layout.
REQ-004 SHALL have port CLK, input, 1, the single clock; all logic on posedge.
REQ-005 SHALL have port RST, input, 1, the reset, synchronous and active-low.
REQ-006 SHALL have port Start, input, 1, a one-cycle pulse that begins a result run.
REQ-007 SHALL have port Num_X, input, DATA_WIDTH, the X values per T step, sampled with Start.
REQ-008 SHALL have port Result_Valid, input, 1, meaning the solver presents a result beat.
REQ-009 SHALL have port Result_Data, input, DATA_WIDTH, the T or X value.
REQ-010 SHALL have port Result_Last, input, 1, which marks the final beat of the run.
REQ-011 SHALL have port Result_Ready, output, 1, meaning the block accepts the beat this cycle.
REQ-012 SHALL have port RAM_Write_Enable, output, 1, the registered write strobe.
REQ-013 SHALL have port RAM_Address, output, ADDRESS_WIDTH, the registered write address.
REQ-014 SHALL have port RAM_Data_Out, output, DATA_WIDTH, the registered write data.
REQ-015 SHALL have port Done_Writing, output, 1, a level that drives Sending_Enable of the result sender.
REQ-016 SHALL have port Overflow_Error, output, 1, a sticky flag meaning T capacity was exceeded.

Function
REQ-017 SHALL use FSM states IDLE, WAIT_T, WAIT_X, WRITE_NT, WRITE_NX, DONE (plus WRITE_CK under the macro).
REQ-018 SHALL, on Start in IDLE or DONE, latch Num_X, clear T_Count and X_Count, deassert Done_Writing and enter WAIT_T; Start in any other state is ignored.
REQ-019 SHALL assert Result_Ready only in WAIT_T and WAIT_X; a beat is accepted when Result_Valid && Result_Ready.
REQ-020 SHALL, for an accepted beat in WAIT_T, write Result_Data to STARTING_OF_T_ADDRESS+T_Count, then go to WAIT_X (or stay in WAIT_T with T_Count+1 when Num_X==0).
REQ-021 SHALL, for an accepted beat in WAIT_X, write to STARTING_OF_X_ADDRESS+T_Count*Num_X+X_Count; on X_Count==Num_X-1 it clears X_Count, increments T_Count and returns to WAIT_T, otherwise it increments X_Count.
REQ-022 SHALL, for an accepted beat with Result_Last=1, write that beat normally and then go to WRITE_NT regardless of group position; a partial group still counts its T.
REQ-023 SHALL, in WRITE_NT, write the final T_Count (zero-extended) to NUMBER_OF_T_ADDRESS; in WRITE_NX, write Num_X to NUMBER_OF_X_ADDRESS; then enter DONE.
REQ-024 SHALL hold Done_Writing=1 in DONE until Start or reset.
REQ-025 SHALL register RAM outputs one cycle after beat acceptance or write state; RAM_Write_Enable is high for exactly one cycle per write and at most one write per cycle.
REQ-026 SHALL compute addresses at full width and truncate to ADDRESS_WIDTH.
REQ-027 SHALL, on a T beat accepted with T_Count==MAX_T, set Overflow_Error, perform no write and treat the beat as Result_Last (go to WRITE_NT with T_Count=MAX_T).
REQ-028 SHALL clear Overflow_Error only on Start or reset.

Reset
REQ-029 SHALL, with RST=0 at a posedge, set state=IDLE and set Result_Ready, RAM_Write_Enable, RAM_Address, RAM_Data_Out, Done_Writing, Overflow_Error, all counters and the latched Num_X to 0.
REQ-030 SHALL abort a run on mid-run reset: no further writes occur and no count words are written.

Configuration
REQ-031 SHALL, with RESULTS_WRITER_CHECKSUM_EN defined, XOR-accumulate every T/X data word written and insert state WRITE_CK after WRITE_NX, which writes the checksum to address 0; Done_Writing is then one cycle later.
REQ-032 SHALL, without the macro, have no checksum logic, no WRITE_CK state and no write to address 0.

Verification
REQ-033 SHALL cover: Start with Num_X=2, then beats 5,6,7,8,9,10 with Last on 10 -> writes (3,5),(10,6),(11,7),(4,8),(12,9),(13,10),(1,2),(2,2), then Done_Writing=1.
REQ-034 SHALL cover: Num_X=0, beats 1,2,3 with Last on 3 -> writes at 3,4,5, then (1,3),(2,0).
REQ-035 SHALL cover: Num_X=1 and 8 T groups -> the 8th T beat sets Overflow_Error and is not written, and address 1 receives 7.
REQ-036 SHALL cover: RST=0 during WAIT_X -> the next cycle has all outputs 0 and no RAM writes until a new Start.
REQ-037 SHALL cover: Start pulsed during WAIT_X -> ignored; the run completes unchanged.
REQ-038 SHALL cover, with the macro defined: beats 0x3,0x5 and Num_X=1 -> address 0 receives 0x6 after address 2, then Done_Writing=1.
